// File: rtl/seg_scan_display_if.sv
// Bundles the counter-side inputs and the display-side outputs of the
// seven-segment scanner.
//   master : drives value_in / value_strobe / blank_empty, observes the display
//   slave  : the scanner itself
// Signals:
//   value_in      4           counter value from the display counter
//   value_strobe  1           1-cycle pulse, same cycle as the counter's enable
//   blank_empty   1           1: digits that never captured a value are dark
//   seg_out       7           segments {g,f,e,d,c,b,a}
//   digit_en      NUM_DIGITS  one-hot active-high digit select
//   digit_idx     clog2(N)    index of the digit currently driven
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]                    value_in;
    logic                          value_strobe;
    logic                          blank_empty;
    logic [6:0]                    seg_out;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic [$clog2(NUM_DIGITS)-1:0] digit_idx;

    modport master (
        output value_in, value_strobe, blank_empty,
        input  seg_out, digit_en, digit_idx
    );

    modport slave (
        input  value_in, value_strobe, blank_empty,
        output seg_out, digit_en, digit_idx
    );
endinterface

// File: rtl/seg_scan_display.sv
// Seven-segment scanner for the display counter. Keeps the last NUM_DIGITS
// counter values (newest in digit 0) and time-multiplexes them onto a
// shared segment bus, each digit staying selected for REFRESH_DIV cycles.
// Ports:
//   clock  in   system clock, all state on posedge
//   reset  in   synchronous, active-high
//   bus    slave modport of seg_scan_display_if (value_in, value_strobe,
//          blank_empty in; seg_out, digit_en, digit_idx out, all registered)
module seg_scan_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                clock,
    input  logic                reset,
    seg_scan_display_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIGIT0_EN = NUM_DIGITS'(1);

    // Hex digit to active-high segment code {g,f,e,d,c,b,a}.
    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'h0:    c = 7'h3F;
            4'h1:    c = 7'h06;
            4'h2:    c = 7'h5B;
            4'h3:    c = 7'h4F;
            4'h4:    c = 7'h66;
            4'h5:    c = 7'h6D;
            4'h6:    c = 7'h7D;
            4'h7:    c = 7'h07;
            4'h8:    c = 7'h7F;
            4'h9:    c = 7'h6F;
            4'hA:    c = 7'h77;
            4'hB:    c = 7'h7C;
            4'hC:    c = 7'h39;
            4'hD:    c = 7'h5E;
            4'hE:    c = 7'h79;
            4'hF:    c = 7'h71;
            default: c = 7'h00;
        endcase
        return c;
    endfunction

    logic                  strobe_d_r;
    logic [3:0]            hist_r [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] vld_r;
    logic [CNT_W-1:0]      ref_cnt_r;
    logic [IDX_W-1:0]      scan_idx_r;
    logic [6:0]            seg_out_r;
    logic [NUM_DIGITS-1:0] digit_en_r;
    logic [IDX_W-1:0]      digit_idx_r;

    logic                  ref_last_s;
    logic                  scan_last_s;
    logic [6:0]            code_s;
    logic [6:0]            seg_next_s;

    // Capture: the strobe is delayed one cycle so value_in is sampled after
    // the upstream counter has already incremented.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_d_r <= 1'b0;
            vld_r      <= {NUM_DIGITS{1'b0}};
            for (int k = 0; k < NUM_DIGITS; k++) begin
                hist_r[k] <= 4'h0;
            end
        end else begin
            strobe_d_r <= bus.value_strobe;
            if (strobe_d_r) begin
                hist_r[0] <= bus.value_in;
                for (int k = 1; k < NUM_DIGITS; k++) begin
                    hist_r[k] <= hist_r[k-1];
                end
                vld_r <= {vld_r[NUM_DIGITS-2:0], 1'b1};
            end else begin
                vld_r <= vld_r;
            end
        end
    end

    // Terminal counts of the refresh divider and the digit scan.
    always_comb begin
        ref_last_s  = (ref_cnt_r == CNT_W'(REFRESH_DIV - 1));
        scan_last_s = (scan_idx_r == IDX_W'(NUM_DIGITS - 1));
    end

    // Refresh divider and scan index; explicit wrap keeps non-power-of-2
    // digit counts legal.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_cnt_r  <= {CNT_W{1'b0}};
            scan_idx_r <= {IDX_W{1'b0}};
        end else if (ref_last_s) begin
            ref_cnt_r  <= {CNT_W{1'b0}};
            scan_idx_r <= scan_last_s ? {IDX_W{1'b0}} : (scan_idx_r + IDX_W'(1));
        end else begin
            ref_cnt_r  <= ref_cnt_r + CNT_W'(1);
        end
    end

    // Segment pattern for the digit currently selected by the scan.
    always_comb begin
        code_s = enc(hist_r[scan_idx_r]);
        if (bus.blank_empty && !vld_r[scan_idx_r]) begin
            seg_next_s = SEG_OFF;
        end else if (SEG_ACTIVE_LOW != 0) begin
            seg_next_s = ~code_s;
        end else begin
            seg_next_s = code_s;
        end
    end

    // Output register: one cycle behind scan index and history.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_out_r   <= SEG_OFF;
            digit_en_r  <= {NUM_DIGITS{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
        end else begin
            seg_out_r   <= seg_next_s;
            digit_en_r  <= DIGIT0_EN << scan_idx_r;
            digit_idx_r <= scan_idx_r;
        end
    end

    assign bus.seg_out   = seg_out_r;
    assign bus.digit_en  = digit_en_r;
    assign bus.digit_idx = digit_idx_r;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, refresh 4, active-low).
// A queue-based model predicts outputs every cycle; directed phases add
// literal expectations.
module tb_seg_scan_display;
    localparam int ND = 4;
    localparam int RD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_display #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] code_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         hist_q [$];
    int         cyc = 0;
    bit         pend = 1'b0;
    bit         model_ready = 1'b0;
    logic [6:0] exp_seg;
    logic [3:0] exp_en;
    int         exp_idx;

    initial begin
        int idx;
        int val;
        bit valid;
        forever begin
            @(posedge clock);
            if (reset) begin
                hist_q.delete();
                cyc     = 0;
                pend    = 1'b0;
                exp_seg = 7'h7F;
                exp_en  = 4'b0000;
                exp_idx = 0;
            end else begin
                idx     = (cyc / RD) % ND;
                exp_idx = idx;
                exp_en  = 4'(1 << idx);
                valid   = (idx < hist_q.size());
                val     = valid ? hist_q[idx] : 0;
                exp_seg = (bus.blank_empty && !valid) ? 7'h7F : ~code_tab[val];
                if (pend) begin
                    hist_q.push_front(int'(bus.value_in));
                    if (hist_q.size() > ND) void'(hist_q.pop_back());
                end
                pend = bus.value_strobe;
                cyc++;
            end
            model_ready = 1'b1;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clock) begin
        if (model_ready) begin
            chk("model_seg_out", int'(bus.seg_out), int'(exp_seg));
            chk("model_digit_en", int'(bus.digit_en), int'(exp_en));
            chk("model_digit_idx", int'(bus.digit_idx), exp_idx);
        end
    end

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (int'(bus.digit_idx) != target && n < 40) begin
            tick(1);
            n++;
        end
        chk("wait_digit_idx", int'(bus.digit_idx), target);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        logic [3:0] rot;
        logic [6:0] exp4 [4];
        int         run;
        bit         first;

        bus.value_in     = 4'h0;
        bus.value_strobe = 1'b0;
        bus.blank_empty  = 1'b1;
        reset            = 1'b1;

        // 1: reset state, then first cycle after release
        tick(3);
        chk("rst_seg", int'(bus.seg_out), 7'h7F);
        chk("rst_en", int'(bus.digit_en), 4'b0000);
        chk("rst_idx", int'(bus.digit_idx), 0);
        reset = 1'b0;
        tick(1);
        chk("rel_en", int'(bus.digit_en), 4'b0001);
        chk("rel_seg", int'(bus.seg_out), 7'h7F);

        // 2: single capture of value 5
        bus.value_strobe = 1'b1;
        tick(1);
        bus.value_strobe = 1'b0;
        bus.value_in     = 4'h5;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            chk("one_capture_seg", int'(bus.seg_out), (bus.digit_en == 4'b0001) ? 7'h12 : 7'h7F);
            tick(1);
        end

        // 3: free-run, rotation and dwell time
        prev  = bus.digit_en;
        run   = 1;
        first = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            cur = bus.digit_en;
            if (cur == prev) begin
                run++;
            end else begin
                if (!first) chk("dwell_cycles", run, 4);
                rot = (prev == 4'b1000) ? 4'b0001 : (prev << 1);
                chk("rotate", int'(cur), int'(rot));
                first = 1'b0;
                run   = 1;
            end
            prev = cur;
        end

        // 4: back-to-back strobes, values 1..6
        for (int i = 0; i <= 6; i++) begin
            bus.value_strobe = (i < 6);
            bus.value_in     = 4'(i);
            tick(1);
        end
        bus.value_in = 4'h0;
        tick(2);
        exp4[0] = 7'h02;
        exp4[1] = 7'h12;
        exp4[2] = 7'h19;
        exp4[3] = 7'h30;
        for (int i = 0; i < 16; i++) begin
            chk("burst_seg", int'(bus.seg_out), int'(exp4[bus.digit_idx]));
            tick(1);
        end

        // 5: no blanking, empty history shows zeros
        reset = 1'b1;
        bus.blank_empty = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 16; i++) begin
            chk("noblank_seg", int'(bus.seg_out), 7'h40);
            tick(1);
        end

        // 6: reset mid-scan with two valid digits
        bus.blank_empty  = 1'b1;
        bus.value_strobe = 1'b1;
        tick(1);
        bus.value_in = 4'h7;
        tick(1);
        bus.value_strobe = 1'b0;
        bus.value_in     = 4'h8;
        tick(1);
        bus.value_in = 4'h0;
        wait_idx(2);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_seg", int'(bus.seg_out), 7'h7F);
        chk("mid_rst_en", int'(bus.digit_en), 4'b0000);
        chk("mid_rst_idx", int'(bus.digit_idx), 0);
        reset = 1'b0;
        tick(1);
        chk("mid_rel_en", int'(bus.digit_en), 4'b0001);
        chk("mid_rel_idx", int'(bus.digit_idx), 0);
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_blank", int'(bus.seg_out), 7'h7F);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
